// File: rtl/alarm_clock_ctrl.sv
// Alarm clock user-interface sequencer: key synchronizers and debouncers, the mode FSM
// (run / set time / set alarm) with press and auto-repeat step strobes, and the
// ring / snooze / dismiss alarm FSM.
module alarm_clock_ctrl #(
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned HOLD_TICKS   = 3,
  parameter int unsigned SNOOZE_TICKS = 600,
  parameter int unsigned RING_TICKS   = 120
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick_2hz,
  input  logic i_key_mode,
  input  logic i_key_adv,
  input  logic i_alarm_en,
  input  logic i_alarm_match,
  output logic o_run,
  output logic o_time_set,
  output logic o_alarm_set,
  output logic o_sthrs1min0,
  output logic o_adv_pulse,
  output logic o_ring,
  output logic o_snoozing
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_TICKS + 1);
  localparam int unsigned RING_W = $clog2(RING_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_TICKS - 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TICKS - 1);

  localparam logic [2:0] MODE_RUN       = 3'd0;
  localparam logic [2:0] MODE_SET_T_MIN = 3'd1;
  localparam logic [2:0] MODE_SET_T_HR  = 3'd2;
  localparam logic [2:0] MODE_SET_A_MIN = 3'd3;
  localparam logic [2:0] MODE_SET_A_HR  = 3'd4;

  localparam logic [1:0] AL_IDLE    = 2'd0;
  localparam logic [1:0] AL_RINGING = 2'd1;
  localparam logic [1:0] AL_SNOOZE  = 2'd2;

  // Key lanes: index 0 = mode key, index 1 = advance/snooze key
  logic [1:0]      w_keys;
  logic [1:0]      r_sync1, r_sync2, r_level, r_level_q, r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  logic              w_press_mode, w_press_adv, w_adv_level;
  logic [2:0]        r_mode, w_mode_next;
  logic              w_mode_step, w_in_set, w_repeat;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_adv_pulse;

  logic [1:0]        r_alarm, w_alarm_d;
  logic              r_fired, w_fired_d;
  logic [RING_W-1:0] r_ring_cnt, w_ring_cnt_d;
  logic [SNZ_W-1:0]  r_snz_cnt, w_snz_cnt_d;

  assign w_keys       = {i_key_adv, i_key_mode};
  assign w_press_mode = r_press[0];
  assign w_press_adv  = r_press[1];
  assign w_adv_level  = r_level[1];

  // Synchronize raw keys, accept a new level after DB_CYCLES equal samples, register rising edges
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_level     <= '0;
      r_level_q   <= '0;
      r_press     <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1   <= w_keys;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_level[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db_cnt[k] <= '0;
          r_level[k]  <= r_sync2[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Mode presses are swallowed by the alarm FSM while it is ringing or snoozing
  assign w_mode_step = w_press_mode & (r_alarm == AL_IDLE);
  assign w_in_set    = (r_mode != MODE_RUN);
  assign w_repeat    = i_tick_2hz & w_adv_level & (r_hold_cnt == HOLD_MAX);

  // Next mode in the RUN -> SET_T_MIN -> SET_T_HR -> SET_A_MIN -> SET_A_HR -> RUN ring
  always_comb begin
    w_mode_next = r_mode;
    if (w_mode_step) begin
      case (r_mode)
        MODE_RUN:       w_mode_next = MODE_SET_T_MIN;
        MODE_SET_T_MIN: w_mode_next = MODE_SET_T_HR;
        MODE_SET_T_HR:  w_mode_next = MODE_SET_A_MIN;
        MODE_SET_A_MIN: w_mode_next = MODE_SET_A_HR;
        default:        w_mode_next = MODE_RUN;
      endcase
    end
  end

  // Mode register, hold-to-repeat counter and the merged press/repeat step strobe
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode      <= MODE_RUN;
      r_hold_cnt  <= '0;
      r_adv_pulse <= 1'b0;
    end else begin
      r_mode      <= w_mode_next;
      r_adv_pulse <= w_in_set & (w_press_adv | w_repeat);
      if (w_mode_step || !w_adv_level) begin
        r_hold_cnt <= '0;
      end else if (i_tick_2hz && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Alarm next state; fired blocks a retrigger until the matching minute has passed
  always_comb begin
    w_alarm_d    = r_alarm;
    w_fired_d    = r_fired & i_alarm_match;
    w_ring_cnt_d = r_ring_cnt;
    w_snz_cnt_d  = r_snz_cnt;
    if (w_mode_step && (w_mode_next != MODE_RUN)) begin
      w_alarm_d = AL_IDLE;
      w_fired_d = 1'b1;
    end else if (!i_alarm_en) begin
      w_alarm_d = AL_IDLE;
    end else begin
      case (r_alarm)
        AL_IDLE: begin
          if (i_alarm_match && (r_mode == MODE_RUN) && !r_fired) begin
            w_alarm_d    = AL_RINGING;
            w_ring_cnt_d = '0;
          end
        end
        AL_RINGING: begin
          if (w_press_mode) begin
            w_alarm_d = AL_IDLE;
            w_fired_d = 1'b1;
          end else if (w_press_adv) begin
            w_alarm_d   = AL_SNOOZE;
            w_snz_cnt_d = '0;
          end else if (i_tick_2hz) begin
            if (r_ring_cnt == RING_LAST) begin
              w_alarm_d = AL_IDLE;
              w_fired_d = 1'b1;
            end else begin
              w_ring_cnt_d = r_ring_cnt + 1'b1;
            end
          end
        end
        AL_SNOOZE: begin
          if (w_press_mode) begin
            w_alarm_d = AL_IDLE;
            w_fired_d = 1'b1;
          end else if (i_tick_2hz) begin
            if (r_snz_cnt == SNZ_LAST) begin
              w_alarm_d    = AL_RINGING;
              w_ring_cnt_d = '0;
            end else begin
              w_snz_cnt_d = r_snz_cnt + 1'b1;
            end
          end
        end
        default: w_alarm_d = AL_IDLE;
      endcase
    end
  end

  // Alarm state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_alarm    <= AL_IDLE;
      r_fired    <= 1'b0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else begin
      r_alarm    <= w_alarm_d;
      r_fired    <= w_fired_d;
      r_ring_cnt <= w_ring_cnt_d;
      r_snz_cnt  <= w_snz_cnt_d;
    end
  end

  assign o_run        = (r_mode == MODE_RUN);
  assign o_time_set   = (r_mode == MODE_SET_T_MIN) | (r_mode == MODE_SET_T_HR);
  assign o_alarm_set  = (r_mode == MODE_SET_A_MIN) | (r_mode == MODE_SET_A_HR);
  assign o_sthrs1min0 = (r_mode == MODE_SET_T_HR) | (r_mode == MODE_SET_A_HR);
  assign o_adv_pulse  = r_adv_pulse;
  assign o_ring       = (r_alarm == AL_RINGING);
  assign o_snoozing   = (r_alarm == AL_SNOOZE);

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed steps plus a random soak, every output compared each
// cycle against an event-level model of the key, mode and alarm rules.
module tb_alarm_clock_ctrl;

  localparam int DB    = 4;
  localparam int HOLD  = 3;
  localparam int SNZ   = 4;
  localparam int RINGT = 5;

  localparam int A_IDLE = 0;
  localparam int A_RING = 1;
  localparam int A_SNZ  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, key_mode = 1'b0, key_adv = 1'b0, alarm_en = 1'b0, alarm_match = 1'b0;
  logic run, time_set, alarm_set, sthrs, adv_pulse, ring, snoozing;

  int tests = 0;
  int fails = 0;
  int adv_count = 0;

  alarm_clock_ctrl #(
    .DB_CYCLES   (DB),
    .HOLD_TICKS  (HOLD),
    .SNOOZE_TICKS(SNZ),
    .RING_TICKS  (RINGT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tick_2hz   (tick),
    .i_key_mode   (key_mode),
    .i_key_adv    (key_adv),
    .i_alarm_en   (alarm_en),
    .i_alarm_match(alarm_match),
    .o_run        (run),
    .o_time_set   (time_set),
    .o_alarm_set  (alarm_set),
    .o_sthrs1min0 (sthrs),
    .o_adv_pulse  (adv_pulse),
    .o_ring       (ring),
    .o_snoozing   (snoozing)
  );

  always #5 clk = ~clk;

  // Reference model. Key presses are scheduled as the edge at which the press takes effect
  // (raw edge + sync 2 + DB samples + level/press registers); adv level is a window of edges.
  int cyc = 0;
  int m_mode = 0;
  int m_alarm = A_IDLE;
  int m_ticks = 0;
  int m_hold = 0;
  bit m_fired = 1'b0;
  bit m_adv = 1'b0;
  int mode_q[$];
  int adv_q[$];
  int adv_lo = 0;
  int adv_hi = -1;
  bit pm, pa, lvl, step, nf;
  int nm;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_alarm = A_IDLE; m_ticks = 0; m_hold = 0; m_fired = 0; m_adv = 0;
      mode_q.delete(); adv_q.delete(); adv_lo = 0; adv_hi = -1;
    end else begin
      cyc++;
      pm = 0;
      pa = 0;
      if (mode_q.size() != 0 && mode_q[0] == cyc) begin pm = 1; void'(mode_q.pop_front()); end
      if (adv_q.size() != 0 && adv_q[0] == cyc) begin pa = 1; void'(adv_q.pop_front()); end
      lvl  = (cyc >= adv_lo) && (cyc <= adv_hi);
      step = pm && (m_alarm == A_IDLE);
      nm   = step ? (m_mode + 1) % 5 : m_mode;
      m_adv = (m_mode != 0) && (pa || (tick && lvl && m_hold >= HOLD));
      if (step || !lvl) m_hold = 0;
      else if (tick && m_hold < HOLD) m_hold++;
      nf = m_fired && alarm_match;
      if (step && nm != 0) begin
        m_alarm = A_IDLE; nf = 1;
      end else if (!alarm_en) begin
        m_alarm = A_IDLE;
      end else if (m_alarm == A_IDLE) begin
        if (alarm_match && m_mode == 0 && !m_fired) begin m_alarm = A_RING; m_ticks = 0; end
      end else if (m_alarm == A_RING) begin
        if (pm) begin m_alarm = A_IDLE; nf = 1; end
        else if (pa) begin m_alarm = A_SNZ; m_ticks = 0; end
        else if (tick) begin
          m_ticks++;
          if (m_ticks == RINGT) begin m_alarm = A_IDLE; nf = 1; end
        end
      end else begin
        if (pm) begin m_alarm = A_IDLE; nf = 1; end
        else if (tick) begin
          m_ticks++;
          if (m_ticks == SNZ) begin m_alarm = A_RING; m_ticks = 0; end
        end
      end
      m_fired = nf;
      m_mode  = nm;
    end
  end

  function automatic logic [6:0] exp_outs();
    return {m_mode == 0, (m_mode == 1) || (m_mode == 2), (m_mode == 3) || (m_mode == 4),
            (m_mode == 2) || (m_mode == 4), m_adv, m_alarm == A_RING, m_alarm == A_SNZ};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; outputs are compared with the model at every falling edge
  task automatic cycles(input int n);
    logic [6:0] obs, exp;
    repeat (n) begin
      @(negedge clk);
      if (adv_pulse === 1'b1) adv_count++;
      if (!reset) begin
        obs = {run, time_set, alarm_set, sthrs, adv_pulse, ring, snoozing};
        exp = exp_outs();
        tests++;
        assert (obs === exp) else begin
          fails++;
          $error("FAIL outputs cyc=%0d observed=%b expected=%b", cyc, obs, exp);
        end
      end
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      cycles(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic adv_down();
    key_adv = 1'b1;
    adv_q.push_back(cyc + DB + 4);
    adv_lo = cyc + DB + 3;
    adv_hi = 32'h7fff_ffff;
  endtask

  task automatic adv_up();
    key_adv = 1'b0;
    adv_hi = cyc + DB + 2;
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    mode_q.push_back(cyc + DB + 4);
    cycles(DB + 2 + int'($urandom_range(0, 6)));
    key_mode = 1'b0;
    cycles(DB + 4);
  endtask

  task automatic press_both();
    key_mode = 1'b1;
    mode_q.push_back(cyc + DB + 4);
    adv_down();
    cycles(DB + 4);
  endtask

  task automatic release_both();
    key_mode = 1'b0;
    adv_up();
    cycles(DB + 4);
  endtask

  task automatic reset_pulse(input string tag);
    key_mode = 1'b0;
    key_adv  = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_int(tag, int'({run, time_set, alarm_set, sthrs, adv_pulse, ring, snoozing}),
                 int'(7'b1000000));
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
  endtask

  initial begin
    cycles(3);
    check_int("reset_outputs", int'({run, time_set, alarm_set, sthrs, adv_pulse, ring, snoozing}),
              int'(7'b1000000));
    reset = 1'b0;
    cycles(3);

    // Short glitch is rejected
    key_mode = 1'b1;
    cycles(3);
    key_mode = 1'b0;
    cycles(DB + 6);
    check_bit("glitch_run", run, 1'b1);

    // Clean press: outputs change exactly 2+DB+2 clks after the raw edge
    key_mode = 1'b1;
    mode_q.push_back(cyc + DB + 4);
    cycles(DB + 3);
    check_bit("pre_latency_run", run, 1'b1);
    cycles(1);
    check_int("set_t_min", int'({run, time_set, sthrs}), int'(3'b010));
    cycles(5);
    key_mode = 1'b0;
    cycles(DB + 4);

    press_mode();
    check_int("set_t_hr", int'({time_set, sthrs}), int'(2'b11));
    press_mode();
    check_int("set_a_min", int'({alarm_set, sthrs}), int'(2'b10));
    press_mode();
    check_int("set_a_hr", int'({alarm_set, sthrs}), int'(2'b11));
    press_mode();
    check_bit("back_to_run", run, 1'b1);

    // Hold adv in SET_T_MIN for 8 ticks: one press pulse plus repeats after HOLD ticks
    press_mode();
    adv_count = 0;
    adv_down();
    cycles(DB + 6);
    ticks(8);
    adv_up();
    cycles(DB + 4);
    check_int("hold_repeat_pulses", adv_count, 1 + (8 - HOLD));
    adv_count = 0;
    ticks(3);
    check_int("released_no_pulse", adv_count, 0);
    repeat (4) press_mode();
    adv_count = 0;
    adv_down();
    cycles(DB + 6);
    ticks(5);
    adv_up();
    cycles(DB + 4);
    check_int("run_no_adv", adv_count, 0);

    // Ring, snooze, re-ring, dismiss
    alarm_en    = 1'b1;
    alarm_match = 1'b1;
    cycles(1);
    check_bit("ring_on_match", ring, 1'b1);
    adv_down();
    cycles(DB + 4);
    check_int("snooze_entered", int'({ring, snoozing}), int'(2'b01));
    cycles(2);
    adv_up();
    cycles(DB + 4);
    ticks(SNZ - 1);
    check_bit("still_snoozing", snoozing, 1'b1);
    do_tick();
    check_bit("snooze_expired_ring", ring, 1'b1);
    press_mode();
    check_int("dismissed", int'({run, ring}), int'(2'b10));
    cycles(20);
    check_bit("no_retrigger", ring, 1'b0);

    // Auto-dismiss after RING_TICKS, re-arm on match drop, enable off
    alarm_match = 1'b0;
    cycles(2);
    alarm_match = 1'b1;
    cycles(1);
    check_bit("retrigger", ring, 1'b1);
    ticks(RINGT - 1);
    check_bit("ring_before_timeout", ring, 1'b1);
    do_tick();
    check_bit("auto_dismiss", ring, 1'b0);
    alarm_match = 1'b0;
    cycles(1);
    alarm_match = 1'b1;
    cycles(1);
    check_bit("rearm", ring, 1'b1);
    alarm_en = 1'b0;
    cycles(1);
    check_bit("enable_off", ring, 1'b0);
    alarm_en = 1'b1;
    cycles(1);
    check_bit("enable_back", ring, 1'b1);

    // Both keys together while ringing: dismiss wins, mode unchanged
    press_both();
    check_int("both_dismiss", int'({run, ring, snoozing}), int'(3'b100));
    cycles(2);
    release_both();

    // Asynchronous reset while ringing and while in SET_A_HR
    alarm_match = 1'b0;
    cycles(1);
    alarm_match = 1'b1;
    cycles(1);
    check_bit("ring_before_reset", ring, 1'b1);
    alarm_match = 1'b0;
    reset_pulse("reset_mid_ring");
    repeat (4) press_mode();
    check_int("set_a_hr_before_reset", int'({alarm_set, sthrs}), int'(2'b11));
    reset_pulse("reset_mid_set");

    // Random soak
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 6))
        0: press_mode();
        1: begin
          adv_down();
          cycles(DB + 2);
          ticks(int'($urandom_range(0, 6)));
          adv_up();
          cycles(DB + 4);
        end
        2: ticks(int'($urandom_range(1, 8)));
        3: begin alarm_match = ~alarm_match; cycles(1); end
        4: begin alarm_en = ($urandom_range(0, 3) != 0); cycles(1); end
        5: begin press_both(); cycles(1); release_both(); end
        default: cycles(int'($urandom_range(1, 10)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
